// File: rtl/cmd_addr_sched_if.sv
// Command handshake bundle between a command source and cmd_addr_sched.
// The source drives the command word and cmd_valid; the scheduler returns cmd_ready.
interface cmd_addr_sched_if #(
    parameter int ADDRESS_NUMBER = 15,
    parameter int BANK_WIDTH     = 3,
    parameter int NUM_RANKS      = 1,
    parameter int WAIT_BITS      = 8
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [ADDRESS_NUMBER-1:0] cmd_a;
    logic [BANK_WIDTH-1:0]     cmd_ba;
    logic [2:0]                cmd_rcw;
    logic [NUM_RANKS-1:0]      cmd_cs;
    logic                      cmd_slot;
    logic [WAIT_BITS-1:0]      cmd_wait;

    modport master (
        output cmd_valid, cmd_a, cmd_ba, cmd_rcw, cmd_cs, cmd_slot, cmd_wait,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_ba, cmd_rcw, cmd_cs, cmd_slot, cmd_wait,
        output cmd_ready
    );
endinterface

// File: rtl/cmd_addr_sched.sv
// DDR3 command/address scheduler: FIFO-buffered commands issued one per clk_div cycle in a chosen slot, NOP-padded.
// Latency: push at edge E issues at E+1 earliest; cmd_ready drops at full, pause/WAIT/TRI stall pops.
module cmd_addr_sched #(
    parameter int ADDRESS_NUMBER  = 15,
    parameter int BANK_WIDTH      = 3,
    parameter int NUM_RANKS       = 1,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int WAIT_BITS       = 8
) (
    input  logic                        clk_div,
    input  logic                        rst_n,
    cmd_addr_sched_if.slave             cmd,
    input  logic [NUM_RANKS-1:0]        cke_in,
    input  logic [NUM_RANKS-1:0]        odt_in,
    input  logic                        pause,
    input  logic                        tri_req,
    output logic [2*ADDRESS_NUMBER-1:0] out_a,
    output logic [2*BANK_WIDTH-1:0]     out_ba,
    output logic [1:0]                  out_ras,
    output logic [1:0]                  out_cas,
    output logic [1:0]                  out_we,
    output logic [2*NUM_RANKS-1:0]      out_cs,
    output logic [2*NUM_RANKS-1:0]      out_cke,
    output logic [2*NUM_RANKS-1:0]      out_odt,
    output logic                        out_tri,
    output logic [FIFO_DEPTH_LOG2:0]    fifo_level,
    output logic                        busy
);
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_LVL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] ST_TRI  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef struct packed {
        logic [ADDRESS_NUMBER-1:0] a;
        logic [BANK_WIDTH-1:0]     ba;
        logic [2:0]                rcw;
        logic [NUM_RANKS-1:0]      cs;
        logic                      slot;
        logic [WAIT_BITS-1:0]      nop_cnt;
    } entry_t;

    entry_t                     mem [DEPTH];
    entry_t                     in_entry;
    entry_t                     head;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   level, level_nxt;
    logic                       rdy_q;
    logic [1:0]                 state;
    logic [WAIT_BITS-1:0]       cnt;
    logic                       push, pop;

    logic [2*ADDRESS_NUMBER-1:0] iss_a;
    logic [2*BANK_WIDTH-1:0]     iss_ba;
    logic [2*NUM_RANKS-1:0]      iss_cs, cke_dup, odt_dup;
    logic [1:0]                  iss_ras, iss_cas, iss_we;

    assign in_entry = {cmd.cmd_a, cmd.cmd_ba, cmd.cmd_rcw, cmd.cmd_cs, cmd.cmd_slot, cmd.cmd_wait};
    assign head     = mem[rd_ptr];

    // cmd_ready is registered so it reads 0 throughout reset and rises on the first edge after release
    assign cmd.cmd_ready = rdy_q;
    assign push      = cmd.cmd_valid & rdy_q;
    assign pop       = (state == ST_IDLE) & ~tri_req & ~pause & (level != '0);
    assign level_nxt = level + LW'(push) - LW'(pop);

    assign fifo_level = level;
    assign out_tri    = (state == ST_TRI);
    assign busy       = (level != '0) | (state == ST_WAIT);

    // Unselected slot is driven high so the other half-cycle is a deselected NOP
    always_comb begin
        iss_a   = '0;
        iss_ba  = '0;
        iss_cs  = '1;
        cke_dup = '0;
        odt_dup = '0;
        for (int i = 0; i < ADDRESS_NUMBER; i++) iss_a[2*i +: 2] = {2{head.a[i]}};
        for (int i = 0; i < BANK_WIDTH; i++)     iss_ba[2*i +: 2] = {2{head.ba[i]}};
        for (int i = 0; i < NUM_RANKS; i++) begin
            iss_cs[2*i +: 2]  = head.slot ? {head.cs[i], 1'b1} : {1'b1, head.cs[i]};
            cke_dup[2*i +: 2] = {2{cke_in[i]}};
            odt_dup[2*i +: 2] = {2{odt_in[i]}};
        end
        iss_ras = head.slot ? {head.rcw[2], 1'b1} : {1'b1, head.rcw[2]};
        iss_cas = head.slot ? {head.rcw[1], 1'b1} : {1'b1, head.rcw[1]};
        iss_we  = head.slot ? {head.rcw[0], 1'b1} : {1'b1, head.rcw[0]};
    end

    always_ff @(posedge clk_div) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rdy_q   <= 1'b0;
            state   <= ST_TRI;
            cnt     <= '0;
            out_a   <= '0;
            out_ba  <= '0;
            out_ras <= 2'b11;
            out_cas <= 2'b11;
            out_we  <= 2'b11;
            out_cs  <= '1;
            out_cke <= '0;
            out_odt <= '0;
        end else begin
            wr_ptr  <= wr_ptr + FIFO_DEPTH_LOG2'(push);
            rd_ptr  <= rd_ptr + FIFO_DEPTH_LOG2'(pop);
            level   <= level_nxt;
            rdy_q   <= (level_nxt < DEPTH_LVL);
            out_cke <= cke_dup;
            out_odt <= odt_dup;
            out_ras <= 2'b11;
            out_cas <= 2'b11;
            out_we  <= 2'b11;
            out_cs  <= '1;
            case (state)
                ST_TRI: begin
                    if (!tri_req) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (tri_req) begin
                        state <= ST_TRI;
                    end else if (pop) begin
                        out_a   <= iss_a;
                        out_ba  <= iss_ba;
                        out_ras <= iss_ras;
                        out_cas <= iss_cas;
                        out_we  <= iss_we;
                        out_cs  <= iss_cs;
                        if (head.nop_cnt != '0) begin
                            state <= ST_WAIT;
                            cnt   <= head.nop_cnt;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - WAIT_BITS'(1);
                    if (cnt == WAIT_BITS'(1)) state <= ST_IDLE;
                end
                default: state <= ST_TRI;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_addr_sched.sv
// Randomised and directed bench for cmd_addr_sched against a queue-based timing model.
module tb_cmd_addr_sched;
    localparam int AN = 15, BW = 3, NR = 1, FL = 4, WB = 8, D = 16;

    logic              clk_div = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     cke_in, odt_in;
    logic              pause, tri_req;
    logic [2*AN-1:0]   out_a;
    logic [2*BW-1:0]   out_ba;
    logic [1:0]        out_ras, out_cas, out_we;
    logic [2*NR-1:0]   out_cs, out_cke, out_odt;
    logic              out_tri;
    logic [FL:0]       fifo_level;
    logic              busy;

    cmd_addr_sched_if #(.ADDRESS_NUMBER(AN), .BANK_WIDTH(BW), .NUM_RANKS(NR), .WAIT_BITS(WB)) cif ();

    cmd_addr_sched #(
        .ADDRESS_NUMBER(AN), .BANK_WIDTH(BW), .NUM_RANKS(NR), .FIFO_DEPTH_LOG2(FL), .WAIT_BITS(WB)
    ) dut (
        .clk_div(clk_div), .rst_n(rst_n), .cmd(cif), .cke_in(cke_in), .odt_in(odt_in),
        .pause(pause), .tri_req(tri_req), .out_a(out_a), .out_ba(out_ba),
        .out_ras(out_ras), .out_cas(out_cas), .out_we(out_we), .out_cs(out_cs),
        .out_cke(out_cke), .out_odt(out_odt), .out_tri(out_tri),
        .fifo_level(fifo_level), .busy(busy)
    );

    always #5 clk_div = ~clk_div;

    typedef struct {
        logic [AN-1:0] a;
        logic [BW-1:0] ba;
        logic [2:0]    rcw;
        logic [NR-1:0] cs;
        logic          slot;
        logic [WB-1:0] w;
    } cmd_t;

    cmd_t        q[$];
    bit          m_tri, m_rdy;
    int          n, next_ok;
    logic [15:0] m_a, m_ba;
    logic [1:0]  e_ras, e_cas, e_we, e_cs, e_cke, e_odt;
    int          checks = 0, failures = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] dup(logic [15:0] x);
        logic [31:0] r;
        for (int i = 0; i < 16; i++) r[2*i +: 2] = {2{x[i]}};
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_tri = 1; m_rdy = 0; next_ok = 0;
        m_a = '0; m_ba = '0;
        e_ras = 2'b11; e_cas = 2'b11; e_we = 2'b11; e_cs = 2'b11;
        e_cke = '0; e_odt = '0;
    endtask

    // One clock edge of the reference: issue rules by cycle number, FIFO as a queue
    task automatic model_edge();
        cmd_t h, c;
        bit pushing;
        pushing = cif.cmd_valid && m_rdy;
        e_ras = 2'b11; e_cas = 2'b11; e_we = 2'b11; e_cs = 2'b11;
        if (m_tri) begin
            if (!tri_req) m_tri = 0;
        end else if (n < next_ok) begin
            // still padding NOPs after the previous command
        end else if (tri_req) begin
            m_tri = 1;
        end else if (q.size() > 0 && !pause) begin
            h = q.pop_front();
            e_ras[h.slot] = h.rcw[2];
            e_cas[h.slot] = h.rcw[1];
            e_we[h.slot]  = h.rcw[0];
            e_cs[h.slot]  = h.cs[0];
            m_a  = {1'b0, h.a};
            m_ba = {13'b0, h.ba};
            next_ok = n + 1 + int'(h.w);
        end
        if (pushing) begin
            c.a = cif.cmd_a; c.ba = cif.cmd_ba; c.rcw = cif.cmd_rcw;
            c.cs = cif.cmd_cs; c.slot = cif.cmd_slot; c.w = cif.cmd_wait;
            q.push_back(c);
        end
        m_rdy = (q.size() < D);
        e_cke = {2{cke_in[0]}};
        e_odt = {2{odt_in[0]}};
        n++;
    endtask

    task automatic check_all();
        check("out_tri", {31'b0, out_tri}, {31'b0, m_tri});
        check("out_ras", {30'b0, out_ras}, {30'b0, e_ras});
        check("out_cas", {30'b0, out_cas}, {30'b0, e_cas});
        check("out_we", {30'b0, out_we}, {30'b0, e_we});
        check("out_cs", {30'b0, out_cs}, {30'b0, e_cs});
        check("out_a", {2'b0, out_a}, dup(m_a));
        check("out_ba", {26'b0, out_ba}, dup(m_ba));
        check("out_cke", {30'b0, out_cke}, {30'b0, e_cke});
        check("out_odt", {30'b0, out_odt}, {30'b0, e_odt});
        check("fifo_level", {27'b0, fifo_level}, q.size());
        check("busy", {31'b0, busy}, {31'b0, (q.size() != 0) || (n < next_ok)});
        check("cmd_ready", {31'b0, cif.cmd_ready}, {31'b0, m_rdy});
    endtask

    task automatic step();
        @(posedge clk_div);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_cmd(logic [AN-1:0] a, logic [BW-1:0] ba, logic [2:0] rcw,
                           logic [NR-1:0] cs, logic slot, logic [WB-1:0] w);
        cif.cmd_valid = 1'b1;
        cif.cmd_a = a; cif.cmd_ba = ba; cif.cmd_rcw = rcw;
        cif.cmd_cs = cs; cif.cmd_slot = slot; cif.cmd_wait = w;
    endtask

    task automatic rand_cmd(int wmax);
        set_cmd(AN'($urandom), BW'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                NR'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                WB'(($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, wmax)));
    endtask

    initial begin
        rst_n = 1'b1;
        cif.cmd_valid = 1'b0;
        set_cmd('0, '0, 3'b111, '1, 1'b0, '0);
        cif.cmd_valid = 1'b0;
        cke_in = '0; odt_in = '0; pause = 1'b0; tri_req = 1'b0;
        n = 0;
        model_reset();
        #1 rst_n = 1'b0;
        #20;
        check_all();
        @(negedge clk_div) rst_n = 1'b1;
        step();

        // Single ACT in slot 1, then a held NOP cycle
        cke_in = 1'b1; odt_in = 1'b1;
        set_cmd(15'h1234, 3'd5, 3'b011, 1'b0, 1'b1, 8'd0);
        step();
        cif.cmd_valid = 1'b0;
        repeat (3) step();

        // Spacing: waits 0, 3, 0 pushed back-to-back
        set_cmd(15'h0001, 3'd1, 3'b101, 1'b0, 1'b0, 8'd0); step();
        set_cmd(15'h7f00, 3'd2, 3'b100, 1'b0, 1'b1, 8'd3); step();
        set_cmd(15'h2aaa, 3'd7, 3'b110, 1'b0, 1'b0, 8'd0); step();
        cif.cmd_valid = 1'b0;
        repeat (8) step();

        // Backpressure: fill with pops inhibited, 17th request must be held
        pause = 1'b1;
        for (int i = 0; i < D + 1; i++) begin
            rand_cmd(0);
            step();
        end
        repeat (2) step();
        cif.cmd_valid = 1'b0;
        pause = 1'b0;
        repeat (D + 4) step();

        // Tristate request arriving during a 4-cycle wait
        set_cmd(15'h0abc, 3'd3, 3'b011, 1'b0, 1'b0, 8'd4); step();
        rand_cmd(0); step();
        tri_req = 1'b1;
        rand_cmd(0); step();
        cif.cmd_valid = 1'b0;
        repeat (8) step();
        tri_req = 1'b0;
        repeat (6) step();

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            cif.cmd_valid = 1'($urandom_range(0, 1));
            rand_cmd(5);
            cif.cmd_valid = 1'($urandom_range(0, 2) != 0);
            pause   = ($urandom_range(0, 3) == 0);
            tri_req = ($urandom_range(0, 19) == 0);
            cke_in  = NR'($urandom_range(0, 1));
            odt_in  = NR'($urandom_range(0, 1));
            step();
        end
        cif.cmd_valid = 1'b0; pause = 1'b0; tri_req = 1'b0;
        repeat (30) step();

        // Reset asserted mid-WAIT with five commands queued
        set_cmd(15'h5555, 3'd6, 3'b010, 1'b0, 1'b1, 8'd8); step();
        for (int i = 0; i < 5; i++) begin
            rand_cmd(0);
            step();
        end
        cif.cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk_div);
        #1 check_all();
        @(negedge clk_div) rst_n = 1'b1;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmd_addr_sched.md
# cmd_addr_sched

Parametrised DDR3 command/address front end running in the clk_div domain, feeding the per-pin cmda_single serializer lanes. Buffers command words in a FIFO and issues at most one command per clk_div cycle in a selectable half-cycle slot, with NOP padding between commands. Holds CKE/ODT levels per rank and interlocks tristating of the bus. Generalises the fixed single-rank command/address path with rank count, FIFO depth and programmable inter-command spacing.

## Interface
- ADDRESS_NUMBER, 15, address pins.
- BANK_WIDTH, 3, bank address pins.
- NUM_RANKS, 1, chip selects / CKE / ODT lanes.
- FIFO_DEPTH_LOG2, 4, command FIFO depth = 2**FIFO_DEPTH_LOG2.
- WAIT_BITS, 8, width of per-command NOP count.

- clk_div  in  1  free-running half-rate clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_a  in  ADDRESS_NUMBER  address.
- cmd_ba  in  BANK_WIDTH  bank.
- cmd_rcw  in  3  {ras,cas,we}, DDR3 active-low encoding (3'b111 = NOP).
- cmd_cs  in  NUM_RANKS  active-low chip selects.
- cmd_slot  in  1  0 = first half of clk_div cycle, 1 = second half.
- cmd_wait  in  WAIT_BITS  NOP cycles inserted after this command.
- cke_in, odt_in  in  NUM_RANKS each  level requests.
- pause  in  1  inhibit FIFO pops.
- tri_req  in  1  request tristate of command/address outputs.
- out_a  out  2*ADDRESS_NUMBER  pin i uses bits [2i+1:2i]; bit 2i = first half.
- out_ba  out  2*BANK_WIDTH  same pairing.
- out_ras, out_cas, out_we  out  2 each  same pairing.
- out_cs  out  2*NUM_RANKS  same pairing.
- out_cke, out_odt  out  2*NUM_RANKS each  same pairing.
- out_tri  out  1  tristate to all lanes.
- fifo_level  out  FIFO_DEPTH_LOG2+1  occupied entries.
- busy  out  1  FIFO non-empty or state WAIT.

## Operation
- FIFO: show-ahead, depth D. cmd_ready = (fifo_level < D), from registered level. Push on cmd_valid & cmd_ready. Simultaneous push+pop keeps level; push into full impossible; pop from empty never occurs.
- FSM states TRI, IDLE, WAIT; reset state TRI.
- TRI: out_tri=1, NOP outputs, no pop. tri_req=0 -> IDLE.
- IDLE: tri_req=1 -> TRI (takes priority over pop). Else if FIFO non-empty and pause=0: pop, issue head; cmd_wait>0 -> WAIT with cnt=cmd_wait, else stay IDLE (back-to-back allowed). Otherwise NOP.
- WAIT: NOP, cnt decrements; cnt==1 -> IDLE. tri_req and pause ignored until IDLE. Exactly cmd_wait NOP cycles follow the issue cycle.
- Issue cycle: selected slot bit of out_ras/cas/we/cs = command values; other slot bit = 1 (NOP, deselect). out_a/out_ba both slots = command address/bank.
- NOP cycle: ras/cas/we/cs both slots = 1; out_a/out_ba hold last issued value (no toggling).
- out_cke/out_odt: both slot bits per rank = registered cke_in/odt_in, every cycle, all states except reset.
- out_tri = 1 exactly while state is TRI.

## Timing
- All outputs registered on clk_div. Reset (asynchronous, any time, including mid-WAIT): FIFO emptied, fifo_level=0, cmd_ready=0 during reset and 1 on first edge after release, state TRI, out_tri=1, out_a=0, out_ba=0, out_ras/cas/we=2'b11, out_cs all 1, out_cke=0, out_odt=0, busy=0.
- Latency: command accepted at edge E with FIFO empty, IDLE, pause=0 appears on out_* after edge E+1.
- Spacing: command issued at edge T with cmd_wait=W; next command issues at edge T+1+W at earliest.
- tri_req high in IDLE: out_tri=1 after next edge. Leaving TRI: first command issue one cycle after reaching IDLE.
- cke_in/odt_in to out_cke/out_odt: 1 cycle.
- fifo_level/busy update on the same edge as push/pop/state change.

## Test plan
- Reset: hold rst_n=0 -> out_tri=1, out_ras/cas/we=2'b11, out_cs=all 1, out_cke=0, fifo_level=0; release with tri_req=0 -> state IDLE after one edge, out_tri=0.
- Single ACT: cmd_rcw=3'b011, cmd_a=15'h1234, cmd_ba=3'd5, cmd_slot=1, cmd_cs=0, wait 0 -> after E+1 out_ras=2'b01, out_cas=out_we=2'b11, out_cs=2'b01, out_a pairs all = 0x1234 bits; next cycle NOP with out_a held.
- Spacing: three commands with cmd_wait 0, 3, 0 pushed back-to-back -> issue edges T, T+1, T+5; NOPs between.
- Backpressure: pause=1, push 17 commands (D=16) -> cmd_ready=0 at fifo_level=16, 17th held; pause=0 -> drains one per cycle in order, fifo_level decrements to 0, busy falls.
- Tristate interlock: tri_req=1 during WAIT cnt=4 -> out_tri stays 0 until WAIT ends, then 1; queued commands not issued until tri_req=0.
- Mid-operation reset: assert rst_n=0 in WAIT with 5 queued -> immediate reset values, fifo_level=0; after release no stale command issues.
